// File: rtl/mips_multicycle_controller_if.sv
// mips_multicycle_controller_if: instruction fields, memory handshake and datapath control bundle
// master: controller side (takes opcode/func/mem_ready, drives every control, status and counter signal)
// slave: datapath side (drives opcode/func/mem_ready, takes the controls)
interface mips_multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [5:0] opcode;
  logic [5:0] func;
  logic mem_ready;
  logic pc_write;
  logic branch_eq;
  logic branch_neq;
  logic [1:0] pc_src;
  logic i_or_d;
  logic mem_read;
  logic mem_write;
  logic ir_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic reg_write;
  logic alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_operation;
  logic illegal_instr;
  logic mem_error;
  logic [CNT_W-1:0] instr_count;
  modport master (
    input opcode, func, mem_ready,
    output pc_write, branch_eq, branch_neq, pc_src, i_or_d, mem_read, mem_write, ir_write,
    output reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_operation,
    output illegal_instr, mem_error, instr_count
  );
  modport slave (
    output opcode, func, mem_ready,
    input pc_write, branch_eq, branch_neq, pc_src, i_or_d, mem_read, mem_write, ir_write,
    input reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_operation,
    input illegal_instr, mem_error, instr_count
  );
endinterface

// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: multi-cycle MIPS control FSM with memory handshake, timeout and retire counter
// Ports: clk, rst (synchronous, active-high); bus (master modport) carries opcode/func/mem_ready in and
// the datapath strobes, illegal_instr, sticky mem_error and instr_count out.
// Build option: define JAL_EN to decode opcode 000011 as jal; otherwise it is an illegal instruction.
module mips_multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  mips_multicycle_controller_if.master bus
);
  localparam int WW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT + 1) : 1;
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, WB_LD, MEM_WR, EXEC_I, WB_I, BRANCH, JUMP,
`ifdef JAL_EN
    JAL,
`endif
    ILLEGAL, ERROR
  } state_t;
  state_t state_q, state_d, dec_d;
  logic [WW-1:0] wait_q;
  logic [CNT_W-1:0] cnt_q;
  logic stall, timeout;
  assign stall = (state_q == FETCH || state_q == MEM_RD || state_q == MEM_WR) && !bus.mem_ready;
  // the cycle whose wait would bring the count to MEM_TIMEOUT is the last one tolerated
  assign timeout = MEM_TIMEOUT != 0 && stall && 32'(wait_q) + 32'd1 == 32'(MEM_TIMEOUT);
  assign bus.instr_count = cnt_q;
  always_comb begin
    dec_d = ILLEGAL;
    case (bus.opcode)
      6'b000000: dec_d = bus.func == 6'd0 ? FETCH : EXEC_R;
      6'b100011, 6'b101011: dec_d = ADDR;
      6'b001000, 6'b001100: dec_d = EXEC_I;
      6'b000100, 6'b000101: dec_d = BRANCH;
      6'b000010: dec_d = JUMP;
`ifdef JAL_EN
      6'b000011: dec_d = JAL;
`endif
      default: dec_d = ILLEGAL;
    endcase
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: state_d = timeout ? ERROR : bus.mem_ready ? DECODE : FETCH;
      DECODE: state_d = dec_d;
      EXEC_R: state_d = WB_R;
      ADDR: state_d = bus.opcode == 6'b101011 ? MEM_WR : MEM_RD;
      MEM_RD: state_d = timeout ? ERROR : bus.mem_ready ? WB_LD : MEM_RD;
      MEM_WR: state_d = timeout ? ERROR : bus.mem_ready ? FETCH : MEM_WR;
      EXEC_I: state_d = WB_I;
      ERROR: state_d = ERROR;
      default: state_d = FETCH;
    endcase
  end
  // every entry into FETCH retires an instruction except the return from ILLEGAL
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      wait_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= state_d != state_q ? '0 : stall ? wait_q + 1'b1 : wait_q;
      if (state_d == FETCH && state_q != FETCH && state_q != ILLEGAL) cnt_q <= cnt_q + 1'b1;
    end
  end
  always_comb begin
    bus.pc_write = 1'b0;
    bus.branch_eq = 1'b0;
    bus.branch_neq = 1'b0;
    bus.pc_src = 2'b00;
    bus.i_or_d = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.ir_write = 1'b0;
    bus.reg_dst = 2'b00;
    bus.mem_to_reg = 2'b00;
    bus.reg_write = 1'b0;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = 2'b00;
    bus.alu_operation = 3'b000;
    bus.illegal_instr = 1'b0;
    bus.mem_error = 1'b0;
    case (state_q)
      FETCH: begin
        bus.mem_read = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.alu_operation = 3'b010;
        bus.ir_write = bus.mem_ready;
        bus.pc_write = bus.mem_ready;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        bus.alu_operation = 3'b010;
      end
      EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_operation = bus.func == 6'b100000 ? 3'b010 :
                            bus.func == 6'b100010 ? 3'b110 :
                            bus.func == 6'b100101 ? 3'b001 :
                            bus.func == 6'b101010 ? 3'b111 : 3'b000;
      end
      WB_R: begin
        bus.reg_write = 1'b1;
        bus.reg_dst = 2'b01;
      end
      ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_operation = 3'b010;
      end
      MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d = 1'b1;
      end
      WB_LD: begin
        bus.reg_write = 1'b1;
        bus.mem_to_reg = 2'b01;
      end
      MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d = 1'b1;
      end
      EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_operation = bus.opcode == 6'b001100 ? 3'b000 : 3'b010;
      end
      WB_I: bus.reg_write = 1'b1;
      BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_operation = 3'b110;
        bus.pc_src = 2'b01;
        bus.branch_eq = bus.opcode == 6'b000100;
        bus.branch_neq = bus.opcode == 6'b000101;
      end
      JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src = 2'b10;
      end
`ifdef JAL_EN
      JAL: begin
        bus.pc_write = 1'b1;
        bus.pc_src = 2'b10;
        bus.reg_write = 1'b1;
        bus.reg_dst = 2'b10;
        bus.mem_to_reg = 2'b10;
      end
`endif
      ILLEGAL: bus.illegal_instr = 1'b1;
      ERROR: bus.mem_error = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb_mips_multicycle_controller: table-driven scoreboard bench for the multi-cycle MIPS controller
module tb_mips_multicycle_controller;
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int stall;
    int lat;
    logic [2:0] op2;
    int ill;
    int mrd;
    int jal;
    int ret;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  logic [3:0] exp_cnt = 4'd0;
  vec_t vecs[$];
  vec_t sb[$];
  mips_multicycle_controller_if #(.CNT_W(4)) bus ();
  mips_multicycle_controller #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  function automatic void add(input logic [5:0] op, input logic [5:0] fn, input int stall, input int lat,
                              input logic [2:0] op2, input int ill, input int mrd, input int jal, input int ret);
    vec_t v;
    v = '{op, fn, stall, lat, op2, ill, mrd, jal, ret};
    vecs.push_back(v);
  endfunction
  // starts and ends at a falling edge with the controller in FETCH
  task automatic run_vec(input vec_t v);
    int c, st, ill, mrd, jal;
    logic [2:0] op2;
    bit done;
    vec_t e;
    sb.push_back(v);
    bus.opcode = v.op;
    bus.func = v.fn;
    st = v.stall;
    c = 0; ill = 0; mrd = 0; jal = 0; op2 = 3'b000; done = 0;
    while (!done && c < 40) begin
      bus.mem_ready = !(((bus.mem_read && bus.i_or_d) || bus.mem_write) && st > 0);
      if (!bus.mem_ready) st--;
      #1;
      ill += int'(bus.illegal_instr);
      mrd += int'(bus.mem_read && bus.i_or_d);
      jal += int'(bus.pc_write && bus.reg_write && bus.reg_dst == 2'b10 && bus.mem_to_reg == 2'b10);
      if (c == 2) op2 = bus.alu_operation;
      @(negedge clk);
      c++;
      done = bus.mem_read && !bus.i_or_d;
    end
    e = sb.pop_front();
    exp_cnt = exp_cnt + 4'(e.ret);
    chk($sformatf("latency op=%b fn=%b", e.op, e.fn), 32'(c), 32'(e.lat));
    if (e.lat > 2) chk($sformatf("alu_op op=%b fn=%b", e.op, e.fn), 32'(op2), 32'(e.op2));
    chk($sformatf("illegal op=%b", e.op), 32'(ill), 32'(e.ill));
    chk($sformatf("mem_rd_cycles op=%b", e.op), 32'(mrd), 32'(e.mrd));
    chk($sformatf("jal_cycles op=%b", e.op), 32'(jal), 32'(e.jal));
    chk($sformatf("instr_count op=%b", e.op), 32'(bus.instr_count), 32'(exp_cnt));
  endtask
  initial begin
    vec_t nop;
    add(6'b000000, 6'b100000, 0, 4, 3'b010, 0, 0, 0, 1);
    add(6'b100011, 6'b000000, 0, 5, 3'b010, 0, 1, 0, 1);
    add(6'b101011, 6'b000000, 0, 4, 3'b010, 0, 0, 0, 1);
    add(6'b000100, 6'b000000, 0, 3, 3'b110, 0, 0, 0, 1);
    add(6'b000000, 6'b100010, 0, 4, 3'b110, 0, 0, 0, 1);
    add(6'b000000, 6'b100100, 0, 4, 3'b000, 0, 0, 0, 1);
    add(6'b000000, 6'b100101, 0, 4, 3'b001, 0, 0, 0, 1);
    add(6'b000000, 6'b101010, 0, 4, 3'b111, 0, 0, 0, 1);
    add(6'b000000, 6'b000111, 0, 4, 3'b000, 0, 0, 0, 1);
    add(6'b001000, 6'b111111, 0, 4, 3'b010, 0, 0, 0, 1);
    add(6'b001100, 6'b000000, 0, 4, 3'b000, 0, 0, 0, 1);
    add(6'b000101, 6'b000000, 0, 3, 3'b110, 0, 0, 0, 1);
    add(6'b000010, 6'b000000, 0, 3, 3'b000, 0, 0, 0, 1);
    add(6'b000000, 6'b000000, 0, 2, 3'b000, 0, 0, 0, 1);
    add(6'b111111, 6'b000000, 0, 3, 3'b000, 1, 0, 0, 0);
    add(6'b100011, 6'b000000, 3, 8, 3'b010, 0, 4, 0, 1);
    add(6'b101011, 6'b000000, 2, 6, 3'b010, 0, 0, 0, 1);
`ifdef JAL_EN
    add(6'b000011, 6'b000000, 0, 3, 3'b000, 0, 0, 1, 1);
`else
    add(6'b000011, 6'b000000, 0, 3, 3'b000, 1, 0, 0, 0);
`endif
    nop = '{6'b000000, 6'b000000, 0, 2, 3'b000, 0, 0, 0, 1};
    bus.opcode = 6'd0;
    bus.func = 6'd0;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_fetch_mem_read", 32'(bus.mem_read), 32'd1);
    chk("rst_fetch_i_or_d", 32'(bus.i_or_d), 32'd0);
    chk("rst_instr_count", 32'(bus.instr_count), 32'd0);
    chk("rst_mem_error", 32'(bus.mem_error), 32'd0);
    chk("rst_illegal", 32'(bus.illegal_instr), 32'd0);
    chk("rst_ir_write_not_ready", 32'(bus.ir_write), 32'd0);
    bus.mem_ready = 1'b1;
    #1;
    chk("fetch_ir_write_ready", 32'(bus.ir_write), 32'd1);
    chk("fetch_pc_write_ready", 32'(bus.pc_write), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) run_vec(vecs[i]);
    bus.opcode = 6'b101011;
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("sw_in_mem_wr", 32'(bus.mem_write), 32'd1);
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 4'd0;
    #1;
    chk("rst_mid_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_mid_fetch", 32'(bus.mem_read && !bus.i_or_d), 32'd1);
    chk("rst_mid_count", 32'(bus.instr_count), 32'd0);
    @(negedge clk);
    repeat (16) run_vec(nop);
    chk("count_wrap", 32'(bus.instr_count), 32'd0);
    bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("timeout_not_yet", 32'(bus.mem_error), 32'd0);
    @(negedge clk);
    #1;
    chk("timeout_error", 32'(bus.mem_error), 32'd1);
    chk("error_no_mem_read", 32'(bus.mem_read), 32'd0);
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("error_sticky", 32'(bus.mem_error), 32'd1);
    chk("error_no_ir_write", 32'(bus.ir_write), 32'd0);
    chk("error_count_held", 32'(bus.instr_count), 32'(exp_cnt));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("error_rst_clear", 32'(bus.mem_error), 32'd0);
    chk("error_rst_fetch", 32'(bus.mem_read && !bus.i_or_d), 32'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
